// File: rtl/z80_block_xfer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : z80_block_xfer_seq
//  Description : Multi-cycle sequencer for the Z80 LDI/LDD/LDIR/LDDR group.
//                It reads (HL), writes that byte to (DE), then steps HL, DE
//                and BC. The repeat forms loop until BC reaches 0 or an
//                interrupt request breaks the loop.
//  Revision    : 1.0  initial release
// ============================================================================
module z80_block_xfer_seq #(
  parameter bit INT_BREAK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir_dec,
  input  logic        repeat_mode,   // 1 = LDIR/LDDR loop
  input  logic [15:0] bc_in,
  input  logic [15:0] de_in,
  input  logic [15:0] hl_in,
  input  logic [7:0]  f_in,
  input  logic        int_pending,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] bc_out,
  output logic [15:0] de_out,
  output logic [15:0] hl_out,
  output logic [7:0]  f_out,
  output logic        ip_rewind,
  output logic [16:0] xfer_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_UPD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bc_q, bc_d;
  logic [15:0] de_q, de_d;
  logic [15:0] hl_q, hl_d;
  logic [7:0]  f_q, f_d;
  logic [7:0]  data_q, data_d;
  logic        dir_q, dir_d;
  logic        rep_q, rep_d;
  logic        rewind_q, rewind_d;
  logic [16:0] xfer_q, xfer_d;

  logic [15:0] bc_dec;
  logic        bc_nz;
  logic        int_brk;

  // BC after this byte and the loop-break condition, used only in UPD
  assign bc_dec  = bc_q - 16'd1;
  assign bc_nz   = |bc_dec;
  assign int_brk = INT_BREAK & int_pending;

  // Next-state and working-register update
  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    de_d     = de_q;
    hl_d     = hl_q;
    f_d      = f_q;
    data_d   = data_q;
    dir_d    = dir_q;
    rep_d    = rep_q;
    rewind_d = rewind_q;
    xfer_d   = xfer_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bc_d     = bc_in;
          de_d     = de_in;
          hl_d     = hl_in;
          f_d      = f_in;
          dir_d    = dir_dec;
          rep_d    = repeat_mode;
          rewind_d = 1'b0;
          xfer_d   = 17'd0;
          state_d  = S_RD;
        end
      end
      S_RD: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (mem_ack) begin
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        hl_d     = dir_q ? (hl_q - 16'd1) : (hl_q + 16'd1);
        de_d     = dir_q ? (de_q - 16'd1) : (de_q + 16'd1);
        bc_d     = bc_dec;
        xfer_d   = xfer_q + 17'd1;
        // H and N cleared, P/V reports BC != 0, other flags untouched
        f_d      = {f_q[7:5], 1'b0, f_q[3], bc_nz, 1'b0, f_q[0]};
        rewind_d = rep_q & bc_nz;
        if (rep_q && bc_nz && !int_brk) begin
          state_d = S_RD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and working registers; reset clears everything so outputs read 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bc_q     <= 16'd0;
      de_q     <= 16'd0;
      hl_q     <= 16'd0;
      f_q      <= 8'd0;
      data_q   <= 8'd0;
      dir_q    <= 1'b0;
      rep_q    <= 1'b0;
      rewind_q <= 1'b0;
      xfer_q   <= 17'd0;
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      de_q     <= de_d;
      hl_q     <= hl_d;
      f_q      <= f_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      rep_q    <= rep_d;
      rewind_q <= rewind_d;
      xfer_q   <= xfer_d;
    end
  end

  // Bus requests are decoded from state so they drop as soon as state leaves
  assign mem_rd     = (state_q == S_RD);
  assign mem_wr     = (state_q == S_WR);
  assign mem_addr   = (state_q == S_RD) ? hl_q :
                      (state_q == S_WR) ? de_q : 16'd0;
  assign mem_wdata  = (state_q == S_WR) ? data_q : 8'd0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign bc_out     = bc_q;
  assign de_out     = de_q;
  assign hl_out     = hl_q;
  assign f_out      = f_q;
  assign ip_rewind  = rewind_q;
  assign xfer_count = xfer_q;

endmodule
`default_nettype wire

// File: tb/tb_z80_block_xfer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z80_block_xfer_seq
//  Description : Self-checking bench for z80_block_xfer_seq. Two instances
//                (interrupt break enabled / disabled) share the stimulus;
//                one is selected for observation at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_z80_block_xfer_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, dir_dec, rep_in, int_pending, mem_ack;
  logic [15:0] bc_in, de_in, hl_in;
  logic [7:0]  f_in, mem_rdata;

  logic [15:0] o_addr [2];
  logic        o_rd [2];
  logic        o_wr [2];
  logic [7:0]  o_wdata [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic [15:0] o_bc [2];
  logic [15:0] o_de [2];
  logic [15:0] o_hl [2];
  logic [7:0]  o_f [2];
  logic        o_rew [2];
  logic [16:0] o_xfer [2];

  logic [7:0]  mem [65536];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          sel      = 0;

  always #5 clk = ~clk;

  z80_block_xfer_seq #(.INT_BREAK(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .dir_dec(dir_dec),
    .repeat_mode(rep_in), .bc_in(bc_in), .de_in(de_in), .hl_in(hl_in),
    .f_in(f_in), .int_pending(int_pending), .mem_addr(o_addr[0]),
    .mem_rd(o_rd[0]), .mem_wr(o_wr[0]), .mem_wdata(o_wdata[0]),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(o_busy[0]),
    .done(o_done[0]), .bc_out(o_bc[0]), .de_out(o_de[0]), .hl_out(o_hl[0]),
    .f_out(o_f[0]), .ip_rewind(o_rew[0]), .xfer_count(o_xfer[0])
  );

  z80_block_xfer_seq #(.INT_BREAK(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .dir_dec(dir_dec),
    .repeat_mode(rep_in), .bc_in(bc_in), .de_in(de_in), .hl_in(hl_in),
    .f_in(f_in), .int_pending(int_pending), .mem_addr(o_addr[1]),
    .mem_rd(o_rd[1]), .mem_wr(o_wr[1]), .mem_wdata(o_wdata[1]),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(o_busy[1]),
    .done(o_done[1]), .bc_out(o_bc[1]), .de_out(o_de[1]), .hl_out(o_hl[1]),
    .f_out(o_f[1]), .ip_rewind(o_rew[1]), .xfer_count(o_xfer[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"},    32'(o_rd[sel]),    32'd0);
    chk({tag, "_wr"},    32'(o_wr[sel]),    32'd0);
    chk({tag, "_addr"},  32'(o_addr[sel]),  32'd0);
    chk({tag, "_wdata"}, 32'(o_wdata[sel]), 32'd0);
    chk({tag, "_busy"},  32'(o_busy[sel]),  32'd0);
    chk({tag, "_done"},  32'(o_done[sel]),  32'd0);
    chk({tag, "_bc"},    32'(o_bc[sel]),    32'd0);
    chk({tag, "_de"},    32'(o_de[sel]),    32'd0);
    chk({tag, "_hl"},    32'(o_hl[sel]),    32'd0);
    chk({tag, "_f"},     32'(o_f[sel]),     32'd0);
    chk({tag, "_rew"},   32'(o_rew[sel]),   32'd0);
    chk({tag, "_xfer"},  32'(o_xfer[sel]),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; int_pending = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One instruction: the bench acts as memory slave with w wait cycles per
  // ack and checks every bus request plus the final architectural state.
  task automatic run_op(input string tag, input logic d, input logic r,
                        input logic [15:0] bc, input logic [15:0] de,
                        input logic [15:0] hl, input logic [7:0] f,
                        input int w, input int int_at, input bit poke);
    int          n, cyc, wcnt, written, limit, done_cyc;
    bit          got_done;
    logic [15:0] hp, dp, bcf, hl_exp, de_exp;
    logic [7:0]  fexp;
    // Bytes moved: one for LDI/LDD, BC (0 means 65536) for the repeat forms,
    // cut short after byte int_at when the interrupt break is active.
    n = r ? ((bc == 16'd0) ? 65536 : int'(bc)) : 1;
    if (r && sel == 0 && int_at > 0 && int_at < n) n = int_at;
    bcf    = bc - 16'(n);
    hl_exp = d ? hl - 16'(n) : hl + 16'(n);
    de_exp = d ? de - 16'(n) : de + 16'(n);
    fexp   = (f & 8'hE9) | ((bcf != 16'd0) ? 8'h04 : 8'h00);
    hp = hl; dp = de; written = 0; wcnt = 0; got_done = 0; done_cyc = 0;
    @(negedge clk);
    start = 1'b1; dir_dec = d; rep_in = r; bc_in = bc; de_in = de;
    hl_in = hl; f_in = f; int_pending = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    bc_in = 16'($urandom); de_in = 16'($urandom); hl_in = 16'($urandom);
    f_in = 8'($urandom); dir_dec = 1'($urandom); rep_in = 1'($urandom);
    cyc = 0;
    limit = 1 + n * (2 * w + 3) + 10;
    while (!got_done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (poke) start = (cyc == 2);
      int_pending = (int_at > 0 && written >= int_at);
      if (cyc == 1) chk({tag, "_busy"}, 32'(o_busy[sel]), 32'd1);
      if (o_done[sel]) begin
        got_done = 1; done_cyc = cyc;
      end else if (o_rd[sel]) begin
        chk({tag, "_rdexcl"}, 32'(o_wr[sel]), 32'd0);
        chk({tag, "_rdaddr"}, 32'(o_addr[sel]), 32'(hp));
        if (wcnt == w) begin
          mem_ack = 1'b1; mem_rdata = mem[o_addr[sel]]; wcnt = 0;
        end else wcnt++;
      end else if (o_wr[sel]) begin
        chk({tag, "_wraddr"}, 32'(o_addr[sel]), 32'(dp));
        chk({tag, "_wdata"},  32'(o_wdata[sel]), 32'(mem[hp]));
        if (wcnt == w) begin
          mem_ack = 1'b1; mem[o_addr[sel]] = o_wdata[sel];
          written++; wcnt = 0;
          hp = d ? hp - 16'd1 : hp + 16'd1;
          dp = d ? dp - 16'd1 : dp + 16'd1;
        end else wcnt++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    if (got_done) begin
      chk({tag, "_latency"}, 32'(done_cyc), 32'(1 + n * (2 * w + 3)));
      chk({tag, "_bytes"},   32'(written), 32'(n));
      chk({tag, "_hl"},      32'(o_hl[sel]), 32'(hl_exp));
      chk({tag, "_de"},      32'(o_de[sel]), 32'(de_exp));
      chk({tag, "_bc"},      32'(o_bc[sel]), 32'(bcf));
      chk({tag, "_f"},       32'(o_f[sel]), 32'(fexp));
      chk({tag, "_rewind"},  32'(o_rew[sel]), 32'(r && bcf != 16'd0));
      chk({tag, "_xfer"},    32'(o_xfer[sel]), 32'(n));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(o_done[sel]), 32'd0);
      chk({tag, "_idle"},       32'(o_busy[sel]), 32'd0);
      chk({tag, "_hold_hl"},    32'(o_hl[sel]), 32'(hl_exp));
    end
    int_pending = 1'b0;
  endtask

  initial begin
    logic        d, r;
    logic [15:0] bc;
    int          ia;
    int          guard;
    reset = 1'b1; start = 1'b0; dir_dec = 1'b0; rep_in = 1'b0;
    bc_in = '0; de_in = '0; hl_in = '0; f_in = '0;
    int_pending = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // LDD single byte
    mem[16'h1005] = 8'h5A;
    run_op("ldd", 1'b1, 1'b0, 16'h0001, 16'h2005, 16'h1005, 8'hFF, 0, 0, 1'b0);
    chk("ldd_mem", 32'(mem[16'h2005]), 32'h5A);

    // LDI with HL wrap
    run_op("ldi", 1'b0, 1'b0, 16'h0003, 16'h0000, 16'hFFFF, 8'h00, 0, 0, 1'b0);

    // LDIR four bytes, two wait cycles per ack
    run_op("ldir", 1'b0, 1'b1, 16'h0004, 16'($urandom), 16'($urandom),
           8'($urandom), 2, 0, 1'b0);

    // LDDR broken by interrupt after byte 3
    run_op("lddr_int", 1'b1, 1'b1, 16'h0010, 16'($urandom), 16'($urandom),
           8'hFF, 1, 3, 1'b0);

    // BC = 0 repeat wraps to FFFF; interrupt stops it after two bytes
    run_op("ldir_bc0", 1'b0, 1'b1, 16'h0000, 16'($urandom), 16'($urandom),
           8'($urandom), 0, 2, 1'b0);

    // Same LDDR on the instance that ignores interrupts: all 16 bytes
    do_reset();
    sel = 1;
    run_op("lddr_noint", 1'b1, 1'b1, 16'h0010, 16'($urandom), 16'($urandom),
           8'hFF, 1, 3, 1'b0);
    do_reset();
    sel = 0;

    // Randomized instructions, with a stray start pulse while busy
    for (int i = 0; i < 8; i++) begin
      d  = 1'($urandom);
      r  = 1'($urandom);
      bc = 16'(1 + $urandom_range(0, 6));
      ia = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 32'(bc))) : 0;
      run_op($sformatf("rand%0d", i), d, r, bc, 16'($urandom), 16'($urandom),
             8'($urandom), int'($urandom_range(0, 2)), ia, 1'b1);
    end

    // Reset in WR while the write is still unacknowledged
    @(negedge clk);
    start = 1'b1; dir_dec = 1'b0; rep_in = 1'b1; bc_in = 16'h0005;
    de_in = 16'h4000; hl_in = 16'h3000; f_in = 8'hA5;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (guard < 10) begin
      @(negedge clk);
      guard++;
      mem_ack = 1'b0;
      if (o_wr[sel]) break;
      if (o_rd[sel]) begin
        mem_ack = 1'b1; mem_rdata = mem[o_addr[sel]];
      end
    end
    chk("rst_reached_wr", 32'(o_wr[sel]), 32'd1);
    reset = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid");
    reset = 1'b0;
    run_op("after_rst", 1'b0, 1'b1, 16'h0003, 16'($urandom), 16'($urandom),
           8'($urandom), 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/z80_block_xfer_seq.md
Name: z80_block_xfer_seq

Overview:
- Multi-cycle sequencer for the Z80 block-transfer group: LDI, LDD, LDIR and LDDR.
- Drives the memory read/write handshake for each byte: reads (HL), writes the byte to (DE), then steps HL, DE and BC.
- Produces final HL/DE/BC, F and an IP-rewind indication for the execute stage.
- Repeat forms loop internally until BC reaches 0 or an interrupt request breaks the loop.

Parameters:
- INT_BREAK, 1: when 1, int_pending ends a repeat loop after the current byte; when 0, int_pending is ignored.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- dir_dec  in  1  1 = decrement HL/DE (LDD/LDDR); 0 = increment (LDI/LDIR).
- repeat  in  1  1 = LDIR/LDDR loop.
- bc_in, de_in, hl_in  in  16 each  register values at start.
- f_in  in  8  flags at start.
- int_pending  in  1  maskable/NMI request pending.
- mem_addr  out  16  bus address.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; valid when mem_ack is high during a read.
- mem_ack  in  1  completes the current request.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- bc_out, de_out, hl_out  out  16 each  working registers.
- f_out  out  8  result flags.
- ip_rewind  out  1  valid with done; 1 = execute stage leaves IP at the instruction (re-execute), 0 = IP += 2.
- xfer_count  out  17  bytes moved since start.

Behaviour:
- Reset: state = IDLE.
  - All outputs 0: mem_rd, mem_wr, mem_addr, mem_wdata, busy, done, bc/de/hl_out, f_out, ip_rewind, xfer_count.
  - Reset mid-transfer drops mem_rd/mem_wr on the next edge; no partial register update is retained.
- IDLE:
  - On start: latch bc/de/hl/f_in into working registers, latch dir_dec/repeat, clear xfer_count, go to RD.
  - mem_ack in IDLE is ignored.
- RD:
  - mem_rd = 1, mem_addr = HL.
  - On mem_ack: capture mem_rdata into the data register, go to WR.
  - Requests hold steady until ack; wait is unbounded.
- WR:
  - mem_wr = 1, mem_addr = DE, mem_wdata = captured byte.
  - On mem_ack go to UPD.
  - mem_rd and mem_wr are never high together.
- UPD (one cycle), all 16-bit modulo-2^16:
  - HL ±= 1, DE ±= 1 (sign per dir_dec), BC -= 1, xfer_count += 1.
  - F = f_in with H (bit4) = 0, N (bit1) = 0, P/V (bit2) = (BC_new != 0); all other bits preserved.
  - Next state:
    - repeat && BC_new != 0 && !(INT_BREAK && int_pending) -> RD.
    - Otherwise -> DONE.
- DONE:
  - done = 1 for one cycle; ip_rewind = repeat && (BC_new != 0).
  - Outputs hold until the next start; go to IDLE.
- Latency with zero-wait ack:
  - start at edge 0 -> RD cycle 1 -> WR cycle 2 -> UPD cycle 3 -> done at cycle 4.
  - Each extra repeat iteration costs 3 cycles.
- BC = 0 at start with repeat:
  - Wraps to FFFF and loops for 65536 bytes in total; final P/V = 0; xfer_count = 0x10000 (hence 17 bits).
- HL/DE wrap-around (FFFF+1 = 0000, 0000-1 = FFFF) is silent.
- Overlapping HL/DE regions need no special handling: each byte is read, then written.
- start while busy is ignored.
- int_pending is sampled only in UPD.
- busy = 1 in RD/WR/UPD/DONE.

Test Plan:
- LDD, HL=1005, DE=2005, BC=0001, (1005)=5A, F=FF, zero-wait ack -> write 5A to 2005; HL=1004, DE=2004, BC=0000, F=E9; done at cycle 4; ip_rewind=0.
- LDI, HL=FFFF, DE=0000, BC=0003, F=00 -> HL=0000, DE=0001, BC=0002, F=04, xfer_count=1.
- LDIR, BC=0004, 2 wait cycles per ack -> 4 read/write pairs at ascending addresses; done after 1+4×(3+3+1)+... cycles matching the model; BC=0; P/V=0; ip_rewind=0.
- LDDR, BC=0010, int_pending raised during byte 3 -> exits after byte 3; BC=000D, P/V=1, ip_rewind=1. Repeat with INT_BREAK=0 -> runs all 16 bytes.
- LDIR, BC=0000 -> 65536 transfers; final BC=0000, HL=hl_in (wrapped); xfer_count=0x10000.
- reset asserted in WR with mem_ack low -> next cycle mem_wr=0, busy=0, all outputs 0; a start after reset runs normally.
